mem_dump_uart: RTL



---
 rtl/mem_dump_uart.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_dump_uart.sv
// mem_dump_uart: debug readout engine for the data memory's second read port.
// On a start pulse it sweeps word addresses 0..DEPTH-1, captures each 32-bit
// word and sends it over a UART TX line as 4 bytes, MSB byte first, 8N1.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high
//   start          dump request, sampled only while idle
//   read_addr_out  word address to the memory debug port
//   read_out       word returned by the memory debug port
//   tx             UART serial out, idles high
//   busy           high while a dump is in progress
//   done           one-cycle pulse after the final stop bit
module mem_dump_uart #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 256,
    parameter int RD_LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  read_addr_out,
    input  logic [31:0] read_out,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    // The capture step has no cycle of its own: the word is latched on the
    // transition into START_BIT so the per-word period is L + 1 + 40*C.
    typedef enum logic [2:0] {
        IDLE,
        SETADDR,
        WAIT,
        START_BIT,
        DATA,
        STOP,
        NEXT
    } state_t;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [8:0]  ADDR_LAST = 9'(DEPTH - 1);
    localparam logic [1:0]  WAIT_LAST = 2'(RD_LATENCY);

    state_t      state_q, state_d;
    logic [8:0]  addr_q, addr_d;
    logic [1:0]  wait_q, wait_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] shreg_q, shreg_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        bit_end;
    logic        load;
    logic [2:0]  nxt_bit;
    logic [7:0]  cur_byte;

    assign bit_end  = (bit_cnt_q == BIT_LAST);
    assign nxt_bit  = bit_idx_q + 3'd1;
    assign cur_byte = shreg_q[31:24];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wait_q     <= '0;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wait_q     <= wait_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wait_d     = wait_q;
        bit_cnt_d  = '0;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETADDR;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            SETADDR: begin
                if (RD_LATENCY == 0) begin
                    load = 1'b1;
                end else begin
                    wait_d  = 2'd1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    load = 1'b1;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            START_BIT: begin
                bit_cnt_d = bit_end ? '0 : bit_cnt_q + 16'd1;
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = cur_byte[0];
                end
            end
            DATA: begin
                bit_cnt_d = bit_end ? '0 : bit_cnt_q + 16'd1;
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = nxt_bit;
                        tx_d      = cur_byte[nxt_bit];
                    end
                end
            end
            STOP: begin
                bit_cnt_d = bit_end ? '0 : bit_cnt_q + 16'd1;
                if (bit_end) begin
                    if (byte_idx_q == 2'd3) begin
                        if (addr_q == ADDR_LAST) begin
                            state_d = NEXT;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            addr_d  = '0;
                        end else begin
                            state_d = SETADDR;
                            addr_d  = addr_q + 9'd1;
                        end
                    end else begin
                        state_d    = START_BIT;
                        byte_idx_d = byte_idx_q + 2'd1;
                        shreg_d    = {shreg_q[23:0], 8'h00};
                        tx_d       = 1'b0;
                    end
                end
            end
            // Holds the done cycle; start is not sampled here.
            NEXT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            shreg_d    = read_out;
            byte_idx_d = '0;
            tx_d       = 1'b0;
            state_d    = START_BIT;
        end
    end

    assign read_addr_out = addr_q[7:0];
    assign tx            = tx_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
